// File: rtl/lane_pkg.sv
// Shared types for the lane-detection edge path: magnitude mode, per-beat
// sideband and the default gradient threshold.
package lane_pkg;

  typedef enum logic {
    MAG_L2SQ = 1'b0,
    MAG_L1   = 1'b1
  } mag_mode_e;

  localparam int unsigned THRESH_DEFAULT = 22500;

  // Threshold width carried in the sideband; matches 2*GRAD_W for 16-bit gradients.
  localparam int THR_W = 32;

  typedef struct packed {
    logic             eol;
    logic             eof;
    mag_mode_e        mode;
    logic [THR_W-1:0] thr;
  } beat_side_t;

endpackage

// File: rtl/grad_mag.sv
// Two-stage gradient magnitude: absolute values, then squared-L2 or L1 sum
// with saturation. Stages advance together on en.
module grad_mag
  import lane_pkg::*;
#(
  parameter int GRAD_W = 16,
  parameter int MAG_W  = 2*GRAD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_vld,
  input  logic signed [GRAD_W-1:0] gx,
  input  logic signed [GRAD_W-1:0] gy,
  input  mag_mode_e                mode,
  output logic                     out_vld,
  output logic        [MAG_W-1:0]  mag
);

  localparam int SUM_W = 2*GRAD_W + 1;

  // The most negative input maps to 2^(GRAD_W-1), which still fits unsigned.
  function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
  endfunction

  function automatic logic [MAG_W-1:0] sat_mag(input logic [SUM_W-1:0] s);
    return (|s[SUM_W-1:MAG_W]) ? {MAG_W{1'b1}} : s[MAG_W-1:0];
  endfunction

  logic              vld_p0, vld_p1;
  logic [GRAD_W-1:0] ax_p0, ay_p0;
  logic [SUM_W-1:0]  sq_sum, l1_sum;
  logic [MAG_W-1:0]  mag_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_vld;
      vld_p1 <= vld_p0;
    end
  end

  // Stage 1: absolute values
  always_ff @(posedge clk) begin
    if (en) begin
      ax_p0 <= abs_grad(gx);
      ay_p0 <= abs_grad(gy);
    end
  end

  always_comb begin
    sq_sum = SUM_W'(ax_p0) * SUM_W'(ax_p0) + SUM_W'(ay_p0) * SUM_W'(ay_p0);
    l1_sum = SUM_W'(ax_p0) + SUM_W'(ay_p0);
  end

  // Stage 2: magnitude; mode belongs to the beat currently in stage 1
  always_ff @(posedge clk) begin
    if (en) begin
      mag_p1 <= (mode == MAG_L1) ? sat_mag(l1_sum) : sat_mag(sq_sum);
    end
  end

  assign out_vld = vld_p1;
  assign mag     = mag_p1;

endmodule

// File: rtl/edge_detect_pipe.sv
// Streaming gradient-threshold edge detector: valid/ready front end, frame
// config latch, 3-stage stallable pipeline and per-frame edge counter.
module edge_detect_pipe
  import lane_pkg::*;
#(
  parameter int          GRAD_W     = 16,
  parameter int          MAG_W      = 2*GRAD_W,
  parameter int unsigned THRESH_RST = THRESH_DEFAULT,
  parameter int          CNT_W      = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [GRAD_W-1:0] s_gx,
  input  logic signed [GRAD_W-1:0] s_gy,
  input  logic                     s_sof,
  input  logic                     s_eol,
  input  logic                     s_eof,
  input  logic                     cfg_mode,
  input  logic        [MAG_W-1:0]  cfg_thresh,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_edge,
  output logic        [MAG_W-1:0]  m_mag,
  output logic                     m_eol,
  output logic                     m_eof,
  output logic                     frame_done,
  output logic        [CNT_W-1:0]  frame_edges
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic             advance, xfer_in, out_xfer;
  mag_mode_e        act_mode;
  logic [MAG_W-1:0] act_thr;
  beat_side_t       side_in, side_p0;
  logic             eol_p1, eof_p1;
  logic [THR_W-1:0] thr_p1;
  logic             vld_p1;
  logic [MAG_W-1:0] mag_p1;
  logic [CNT_W-1:0] edge_cnt, cnt_next;

  assign advance  = !m_valid || m_ready;
  assign s_ready  = advance;
  assign xfer_in  = s_valid && advance;
  assign out_xfer = m_valid && m_ready;

  // A sof beat uses the freshly sampled config itself, not the stale latch.
  always_comb begin
    side_in.eol  = s_eol;
    side_in.eof  = s_eof;
    side_in.mode = s_sof ? mag_mode_e'(cfg_mode) : act_mode;
    side_in.thr  = THR_W'(s_sof ? cfg_thresh : act_thr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_mode <= MAG_L2SQ;
      act_thr  <= MAG_W'(THRESH_RST);
    end else if (xfer_in && s_sof) begin
      act_mode <= mag_mode_e'(cfg_mode);
      act_thr  <= cfg_thresh;
    end
  end

  grad_mag #(
    .GRAD_W (GRAD_W),
    .MAG_W  (MAG_W)
  ) u_grad_mag (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (advance),
    .in_vld  (xfer_in),
    .gx      (s_gx),
    .gy      (s_gy),
    .mode    (side_p0.mode),
    .out_vld (vld_p1),
    .mag     (mag_p1)
  );

  // Stages 1-2: sideband rides alongside the magnitude datapath
  always_ff @(posedge clk) begin
    if (advance) begin
      side_p0 <= side_in;
      eol_p1  <= side_p0.eol;
      eof_p1  <= side_p0.eof;
      thr_p1  <= side_p0.thr;
    end
  end

  // Stage 3: threshold compare and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_edge  <= 1'b0;
      m_mag   <= '0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (advance) begin
      m_valid <= vld_p1;
      m_edge  <= vld_p1 && (mag_p1 > MAG_W'(thr_p1));
      m_mag   <= mag_p1;
      m_eol   <= vld_p1 && eol_p1;
      m_eof   <= vld_p1 && eof_p1;
    end
  end

  assign cnt_next = m_edge ? sat_inc(edge_cnt) : edge_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt    <= '0;
      frame_edges <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_xfer) begin
        if (m_eof) begin
          frame_edges <= cnt_next;
          edge_cnt    <= '0;
          frame_done  <= 1'b1;
        end else begin
          edge_cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_detect_pipe.sv
// Scoreboard bench for edge_detect_pipe: directed plus randomized frames,
// reference model computes magnitudes, edges and frame counts arithmetically.
module tb_edge_detect_pipe;
  import lane_pkg::*;

  localparam int GRAD_W = 16;
  localparam int MAG_W  = 32;
  localparam int CNT_W  = 20;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam longint MAG_MAX = (longint'(1) << MAG_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic signed [GRAD_W-1:0] s_gx = '0;
  logic signed [GRAD_W-1:0] s_gy = '0;
  logic                     s_sof = 1'b0, s_eol = 1'b0, s_eof = 1'b0;
  logic                     cfg_mode = 1'b0;
  logic        [MAG_W-1:0]  cfg_thresh = 32'd22500;
  logic                     m_valid;
  logic                     m_ready = 1'b1;
  logic                     m_edge;
  logic        [MAG_W-1:0]  m_mag;
  logic                     m_eol, m_eof;
  logic                     frame_done;
  logic        [CNT_W-1:0]  frame_edges;

  edge_detect_pipe #(
    .GRAD_W(GRAD_W), .MAG_W(MAG_W), .THRESH_RST(22500), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_gx(s_gx), .s_gy(s_gy),
    .s_sof(s_sof), .s_eol(s_eol), .s_eof(s_eof),
    .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .m_valid(m_valid), .m_ready(m_ready), .m_edge(m_edge), .m_mag(m_mag),
    .m_eol(m_eol), .m_eof(m_eof),
    .frame_done(frame_done), .frame_edges(frame_edges)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint mag;
    bit     edg;
    bit     eol;
    bit     eof;
  } exp_t;

  exp_t   exp_q[$];
  longint frame_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     rdy_rand = 1'b0;

  bit     mdl_mode = 1'b0;
  longint mdl_thr = 22500;
  longint mdl_cnt = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: config latched on sof, magnitude by plain arithmetic,
  // frame edge total committed on eof.
  function automatic void model_accept(input longint gx, input longint gy,
                                       input bit sof, input bit eol, input bit eof);
    exp_t   e;
    longint ax, ay, mag;
    if (sof) begin
      mdl_mode = cfg_mode;
      mdl_thr  = longint'(cfg_thresh);
    end
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    mag = mdl_mode ? (ax + ay) : (ax * ax + ay * ay);
    if (mag > MAG_MAX) mag = MAG_MAX;
    e.mag = mag;
    e.edg = (mag > mdl_thr);
    e.eol = eol;
    e.eof = eof;
    exp_q.push_back(e);
    if (e.edg && mdl_cnt < CNT_MAX) mdl_cnt++;
    if (eof) begin
      frame_q.push_back(mdl_cnt);
      mdl_cnt = 0;
    end
  endfunction

  function automatic void model_reset();
    mdl_mode = 1'b0;
    mdl_thr  = 22500;
    mdl_cnt  = 0;
    exp_q.delete();
    frame_q.delete();
  endfunction

  // Entered at posedge+1; leaves at posedge+1 after the beat transferred.
  task automatic send_beat(input logic signed [GRAD_W-1:0] gx, input logic signed [GRAD_W-1:0] gy,
                           input bit sof, input bit eol, input bit eof);
    bit done = 1'b0;
    int guard = 0;
    s_valid = 1'b1; s_gx = gx; s_gy = gy; s_sof = sof; s_eol = eol; s_eof = eof;
    while (!done) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
      @(posedge clk);
      guard++;
      if (guard > 1000) begin
        n_bad++;
        $display("FAIL accept_timeout: got no s_ready in %0d cycles, expected acceptance", guard);
        $fatal(1, "input stalled");
      end
    end
    model_accept(longint'(gx), longint'(gy), sof, eol, eof);
    #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_eof = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || frame_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    if (n >= 2000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
  endtask

  function automatic logic signed [GRAD_W-1:0] rand_grad();
    if ($urandom_range(0, 3) == 0) return GRAD_W'($urandom);
    return GRAD_W'($urandom_range(0, 600)) - 16'sd300;
  endfunction

  // Output readiness, changed just after each active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expectations on every output transfer and frame_done
  bit               stalled_prev = 1'b0;
  logic [MAG_W-1:0] held_mag;
  bit               held_edge, held_eol, held_eof;
  initial begin
    exp_t e;
    longint fe;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) begin
          check("hold_valid", longint'(m_valid), 1);
          check("hold_mag", longint'(m_mag), longint'(held_mag));
          check("hold_edge", longint'(m_edge), longint'(held_edge));
          check("hold_eol_eof", longint'({m_eol, m_eof}), longint'({held_eol, held_eof}));
        end
        stalled_prev = m_valid && !m_ready;
        held_mag = m_mag; held_edge = m_edge; held_eol = m_eol; held_eof = m_eof;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_beat: got mag=%0d, expected no beat", m_mag);
          end else begin
            e = exp_q.pop_front();
            check("m_mag", longint'(m_mag), e.mag);
            check("m_edge", longint'(m_edge), longint'(e.edg));
            check("m_eol", longint'(m_eol), longint'(e.eol));
            check("m_eof", longint'(m_eof), longint'(e.eof));
          end
        end
        if (frame_done) begin
          if (frame_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_frame_done: got frame_edges=%0d, expected no pulse", frame_edges);
          end else begin
            fe = frame_q.pop_front();
            check("frame_edges", longint'(frame_edges), fe);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [GRAD_W-1:0] f1_gx[8];
    f1_gx = '{16'sd200, 16'sd10, 16'sd151, 16'sd150, 16'sd300, 16'sd0, 16'sd160, 16'sd1000};

    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", longint'(m_valid), 0);
    check("rst_m_mag", longint'(m_mag), 0);
    check("rst_m_edge", longint'(m_edge), 0);
    check("rst_frame_edges", longint'(frame_edges), 0);
    check("rst_frame_done", longint'(frame_done), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-pixel frame exactly at threshold, then L2 above threshold and extreme corner
    cfg_mode = 1'b0; cfg_thresh = 32'd22500;
    send_beat(16'sd150, 16'sd0, 1, 1, 1);
    send_beat(16'sd151, 16'sd0, 1, 0, 0);
    send_beat(-16'sd32768, -16'sd32768, 0, 1, 1);
    wait_drain();

    // L1 mode around its threshold
    cfg_mode = 1'b1; cfg_thresh = 32'd200;
    send_beat(-16'sd100, 16'sd101, 1, 0, 0);
    send_beat(16'sd100, 16'sd100, 0, 1, 1);
    wait_drain();

    // Mid-frame threshold change ignored until next sof
    cfg_mode = 1'b0; cfg_thresh = 32'd22500;
    send_beat(16'sd10, 16'sd10, 1, 0, 0);
    cfg_thresh = 32'd0;
    send_beat(16'sd10, 16'sd10, 0, 0, 0);
    send_beat(16'sd10, 16'sd10, 0, 1, 1);
    send_beat(16'sd10, 16'sd10, 1, 1, 1);
    wait_drain();

    // Backpressure stream with s_valid held while stalled
    rdy_rand = 1'b1;
    cfg_mode = 1'b0; cfg_thresh = 32'd20000;
    for (int b = 0; b < 10; b++)
      send_beat(16'(140 + 3 * b), 16'sd5, b == 0, b == 9, b == 9);
    wait_drain();
    rdy_rand = 1'b0;

    // 8-beat frame with 5 edges, then reset in the middle of the next frame
    cfg_mode = 1'b0; cfg_thresh = 32'd22500;
    for (int b = 0; b < 8; b++)
      send_beat(f1_gx[b], 16'sd0, b == 0, b == 7, b == 7);
    wait_drain();
    check("frame1_edges", longint'(frame_edges), 5);
    send_beat(16'sd500, 16'sd0, 1, 0, 0);
    send_beat(16'sd500, 16'sd0, 0, 0, 0);
    send_beat(16'sd500, 16'sd0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", longint'(m_valid), 0);
    check("async_rst_frame_edges", longint'(frame_edges), 0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // No sof after reset: default threshold and L2 mode must apply
    cfg_mode = 1'b1; cfg_thresh = 32'd0;
    send_beat(16'sd150, 16'sd0, 0, 1, 1);
    wait_drain();

    // Randomized frames with random gaps, backpressure and mid-frame cfg noise
    rdy_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 12);
      cfg_mode = 1'($urandom_range(0, 1));
      if (cfg_mode) cfg_thresh = 32'($urandom_range(0, 700));
      else if ($urandom_range(0, 3) == 0) cfg_thresh = $urandom;
      else cfg_thresh = 32'($urandom_range(0, 150000));
      for (int b = 0; b < len; b++) begin
        if (b > 0 && $urandom_range(0, 3) == 0) begin
          cfg_mode = 1'($urandom_range(0, 1));
          cfg_thresh = $urandom;
        end
        send_beat(rand_grad(), rand_grad(), b == 0,
                  ($urandom_range(0, 3) == 0) || (b == len - 1), b == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    wait_drain();
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_detect_pipe.md
Name: edge_detect_pipe

Overview:
Streaming, parametrised successor to the combinational gradient-threshold edge detector in the lane detection path. It accepts signed Sobel Gx/Gy beats over a valid/ready handshake and computes either the squared L2 magnitude or the L1 magnitude. The magnitude is compared against a per-frame threshold latched at start of frame. The block emits an edge bit plus the magnitude through a 3-stage stallable pipeline, and counts edge pixels per frame for the downstream lane-fit / Hough stage.

Parameters:
GRAD_W, 16, width of signed Gx/Gy inputs
MAG_W, 2*GRAD_W, width of the magnitude output and threshold; fixed at 2*GRAD_W
THRESH_RST, 22500, active threshold value out of reset
CNT_W, 20, width of the per-frame edge counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  block can accept a beat
s_gx  in  GRAD_W  signed gradient X
s_gy  in  GRAD_W  signed gradient Y
s_sof  in  1  first pixel of frame
s_eol  in  1  last pixel of line
s_eof  in  1  last pixel of frame
cfg_mode  in  1  0 = squared L2 (Gx²+Gy²), 1 = L1 (|Gx|+|Gy|)
cfg_thresh  in  MAG_W  unsigned threshold, applied at next accepted sof
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts
m_edge  out  1  1 if magnitude > threshold
m_mag  out  MAG_W  unsigned magnitude, saturated
m_eol  out  1  s_eol delayed with its beat
m_eof  out  1  s_eof delayed with its beat
frame_done  out  1  one-cycle pulse when the eof beat transfers on the output
frame_edges  out  CNT_W  edge count of the last completed frame, saturating

Behaviour:
- Reset, async on rst_n low:
  - All stage valids = 0; m_valid = 0; m_edge = 0; m_mag = 0; m_eol = m_eof = 0.
  - frame_done = 0; frame_edges = 0; running count = 0.
  - Active threshold = THRESH_RST; active mode = 0.
- Handshake: advance = !m_valid || m_ready. s_ready = advance. A transfer occurs when s_valid && s_ready. All stages shift together on advance; bubbles propagate as valid = 0. Outputs are held stable while m_valid && !m_ready.
- Latency: exactly 3 cycles from input transfer to m_valid with no stall. Throughput is 1 beat/cycle.
- Config latch: on an accepted beat with s_sof = 1, cfg_mode and cfg_thresh are sampled and that sample is used for this beat and all following beats. Mid-frame cfg changes have no effect. Mode and threshold travel with each beat so in-flight beats keep their own values.
- Stage 1: register |Gx| and |Gy| as GRAD_W-bit unsigned. Abs of the most negative value (−2^(GRAD_W−1)) = 2^(GRAD_W−1), no wrap.
- Stage 2:
  - mode 0: mag = |Gx|² + |Gy|², computed at 2*GRAD_W+1 bits and saturated to 2^MAG_W−1. (−32768,−32768) → 2^31, fits; saturation engages only at the bound.
  - mode 1: mag = |Gx| + |Gy|, zero-extended.
- Stage 3: edge = (mag > thr), strict unsigned compare. mag == thr gives 0. m_mag = mag.
- Counter:
  - On output transfer with m_edge = 1, running count increments, saturating at 2^CNT_W−1.
  - On output transfer with m_eof = 1: frame_edges ← final count including that beat; running count ← 0; frame_done pulses on the following cycle.
  - A sof beat does not clear the count; only eof does.
- Missing eof before the next sof: the count continues. This is a documented protocol violation, with no error flag.
- Simultaneous sof and eof (1-pixel frame) is legal: latch config, then commit the count.
- Reset mid-frame: in-flight beats are dropped; the next frame must begin with sof, otherwise THRESH_RST and mode 0 apply.

Decomposition:
- Shared package lane_pkg:
  - mag_mode_e enum {MAG_L2SQ, MAG_L1}
  - beat sideband struct (eol, eof, mode, thr)
  - THRESH_DEFAULT = 22500
- Sub-module grad_mag: stages 1–2, pipelined magnitude with enable, mode input and saturation. The top holds the handshake, config latch, compare and counter.

Test Plan:
- Reset → m_valid=0, frame_edges=0. Frame of 1 beat, sof=eof=1, Gx=150, Gy=0, thr=22500, mode 0 → m_mag=22500, m_edge=0 (strict compare), frame_done pulse, frame_edges=0.
- Gx=151, Gy=0, mode 0 → m_mag=22801, edge=1. Gx=−32768, Gy=−32768 → m_mag=2147483648, edge=1, no overflow.
- mode 1, thr=200, Gx=−100, Gy=101 → m_mag=201, edge=1. Gx=100, Gy=100 → m_mag=200, edge=0.
- Change cfg_thresh mid-frame from 22500 to 0 with Gx=Gy=10 beats → edge=0 until the next sof beat, then edge=1.
- Backpressure: 10-beat stream, m_ready toggled randomly → every beat is delivered exactly once, in order, with outputs stable while stalled; no loss when s_valid is held under s_ready=0.
- 8-beat frame with 5 edges, eof on beat 8, then assert rst_n low during the next frame mid-stream → frame_edges=5 after frame 1, then 0 immediately on reset; m_valid=0 asynchronously.
